// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshakes on both sides.
//   Single-cycle ops (add/sub/logic/slt/shifts) finish on the accepting edge.
//   Unsigned multiply (shift-add) and divide (restoring) take WIDTH steps.
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   operand handshake; op, a, b captured on transfer
//   out_valid / out_ready result handshake; result, zero, ovf, err held
//                         stable while out_valid=1 and out_ready=0
module alu_mc #(
    parameter int WIDTH  = 32,
    parameter bit MULDIV = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf,
    output logic             err
);

    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t           r_state;
    logic [SHW-1:0]   r_cnt;
    logic [1:0]       r_mdop;    // 00 MULLO, 01 MULHIU, 10 DIVU, 11 REMU
    // r_hi: product high half (MUL) or partial remainder (DIV)
    // r_lo: multiplier shifting out / low product (MUL) or dividend/quotient (DIV)
    // r_opb: multiplicand or divisor
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_ovf;
    logic             r_err;

    logic             w_accept;
    logic             w_is_md;
    logic             w_illegal;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [SHW-1:0]   w_sh;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_ovf;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH-1:0] w_mul_hi_n;
    logic [WIDTH-1:0] w_mul_lo_n;
    logic [WIDTH:0]   w_div_sh;
    logic [WIDTH:0]   w_div_sub;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_rem_n;
    logic [WIDTH-1:0] w_quo_n;
    logic [WIDTH-1:0] w_md_res;

    // In DONE a new op may be accepted on the same edge that hands off the result.
    assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
    assign out_valid = (r_state == S_DONE);
    assign w_accept  = in_valid && in_ready;
    assign result    = r_result;
    assign zero      = r_zero;
    assign ovf       = r_ovf;
    assign err       = r_err;

    assign w_is_md   = (op[3:2] == 2'b11);
    assign w_illegal = (op == 4'b1011) || (w_is_md && !MULDIV);
    assign w_sum     = a + b;
    assign w_diff    = a - b;
    assign w_sh      = b[SHW-1:0];

    always_comb begin
        w_alu_res = '0;
        w_alu_ovf = 1'b0;
        case (op)
            4'b0000: begin
                w_alu_res = w_sum;
                w_alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            4'b0001: begin
                w_alu_res = w_diff;
                w_alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            4'b0010: w_alu_res = a & b;
            4'b0011: w_alu_res = a | b;
            4'b0100: w_alu_res = a ^ b;
            4'b0101: w_alu_res = ~(a | b);
            4'b0110: w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            4'b0111: w_alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            4'b1000: w_alu_res = a << w_sh;
            4'b1001: w_alu_res = a >> w_sh;
            4'b1010: w_alu_res = $signed(a) >>> w_sh;
            default: w_alu_res = '0;
        endcase
    end

    // One shift-add multiply step: add multiplicand when the multiplier LSB is
    // set, then shift the {hi, lo} pair right, carry falling into hi's MSB.
    assign w_mul_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : {(WIDTH+1){1'b0}});
    assign w_mul_hi_n = w_mul_sum[WIDTH:1];
    assign w_mul_lo_n = {w_mul_sum[0], r_lo[WIDTH-1:1]};

    // One restoring-divide step: bring the next dividend bit into the partial
    // remainder and subtract the divisor if it fits. A zero divisor always
    // "fits", which naturally yields all-ones quotient and remainder = a.
    assign w_div_sh  = {r_hi, r_lo[WIDTH-1]};
    assign w_div_sub = w_div_sh - {1'b0, r_opb};
    assign w_div_ge  = (w_div_sh >= {1'b0, r_opb});
    assign w_rem_n   = w_div_ge ? w_div_sub[WIDTH-1:0] : w_div_sh[WIDTH-1:0];
    assign w_quo_n   = {r_lo[WIDTH-2:0], w_div_ge};

    always_comb begin
        w_md_res = '0;
        case (r_mdop)
            2'b00:   w_md_res = w_mul_lo_n;
            2'b01:   w_md_res = w_mul_hi_n;
            2'b10:   w_md_res = w_quo_n;
            default: w_md_res = w_rem_n;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_mdop   <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opb    <= '0;
            r_result <= '0;
            r_zero   <= 1'b1;
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
        end else if (r_state == S_BUSY) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_mdop[1]) begin
                r_hi <= w_rem_n;
                r_lo <= w_quo_n;
            end else begin
                r_hi <= w_mul_hi_n;
                r_lo <= w_mul_lo_n;
            end
            // Last step: result is taken from the step's next-state values.
            if (r_cnt == SHW'(WIDTH-1)) begin
                r_result <= w_md_res;
                r_zero   <= (w_md_res == '0);
                r_ovf    <= 1'b0;
                r_state  <= S_DONE;
            end
        end else if (w_accept) begin
            r_err <= w_illegal;
            if (w_illegal) begin
                r_result <= '0;
                r_zero   <= 1'b1;
                r_ovf    <= 1'b0;
                r_state  <= S_DONE;
            end else if (w_is_md) begin
                r_mdop  <= op[1:0];
                r_cnt   <= '0;
                r_hi    <= '0;
                r_lo    <= a;
                r_opb   <= b;
                r_state <= S_BUSY;
            end else begin
                r_result <= w_alu_res;
                r_zero   <= (w_alu_res == '0);
                r_ovf    <= w_alu_ovf;
                r_state  <= S_DONE;
            end
        end else if ((r_state == S_DONE) && out_ready) begin
            r_state <= S_IDLE;
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: self-checking bench for alu_mc (WIDTH=32, MULDIV=1).
// A reference model computes each accepted op's outputs with plain
// arithmetic; a monitor compares every cycle out_valid is high. Directed
// sequences add literal expectations, latency and handshake checks.
module tb_alu_mc;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        o;
        logic        e;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        ovf;
    logic        err;

    int   checks = 0;
    int   fails  = 0;
    bit   rnd_rdy = 1'b0;
    exp_t q[$];

    alu_mc #(.WIDTH(32), .MULDIV(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .ovf       (ovf),
        .err       (err)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        longint      sx;
        longint      sy;
        longint      s;
        logic [63:0] p;
        int          sh;
        e  = '0;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        sh = int'(y[4:0]);
        p  = {32'd0, x} * {32'd0, y};
        case (o)
            4'h0: begin e.res = x + y; s = sx + sy; e.o = (s != longint'($signed(e.res))); end
            4'h1: begin e.res = x - y; s = sx - sy; e.o = (s != longint'($signed(e.res))); end
            4'h2: e.res = x & y;
            4'h3: e.res = x | y;
            4'h4: e.res = x ^ y;
            4'h5: e.res = ~(x | y);
            4'h6: e.res = (sx < sy) ? 32'd1 : 32'd0;
            4'h7: e.res = (x < y) ? 32'd1 : 32'd0;
            4'h8: e.res = x << sh;
            4'h9: e.res = x >> sh;
            4'hA: e.res = $signed(x) >>> sh;
            4'hC: e.res = p[31:0];
            4'hD: e.res = p[63:32];
            4'hE: e.res = (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
            4'hF: e.res = (y == 32'd0) ? x : x % y;
            default: e.e = 1'b1;
        endcase
        e.z = (e.res == 32'd0);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Present an op and hold it until accepted; returns 1 time unit after the
    // accepting edge with in_valid still asserted.
    task automatic send(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        int n;
        n        = 0;
        in_valid = 1'b1;
        op       = o;
        a        = x;
        b        = y;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(posedge clk);
            #1;
            if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("result_timeout", {31'd0, out_valid}, 32'd1);
    endtask

    // Monitor: compare held outputs against the model's queue every valid cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            if (out_valid) begin
                checks++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL spurious_out_valid: got result=%h with no pending op", result);
                end else if ({result, zero, ovf, err} !== q[0]) begin
                    fails++;
                    $display("FAIL model_cmp: got res=%h z=%b o=%b e=%b expected res=%h z=%b o=%b e=%b",
                             result, zero, ovf, err, q[0].res, q[0].z, q[0].o, q[0].e);
                end
                if (out_ready && q.size() != 0) void'(q.pop_front());
            end
            if (in_valid && in_ready) q.push_back(model(op, a, b));
        end
    end

    logic [31:0] va [4];
    logic [31:0] vb [4];

    initial begin
        int n;
        int rdy_seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = 4'h0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd1);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // 1: signed overflow on ADD
        send(4'h0, 32'h7FFF_FFFF, 32'h1);
        in_valid = 1'b0;
        chk("t1_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_result", result, 32'h8000_0000);
        chk("t1_ovf", {31'd0, ovf}, 32'd1);
        chk("t1_zero", {31'd0, zero}, 32'd0);
        idle();

        // 2: back-to-back SUB then SLT
        send(4'h1, 32'd5, 32'd5);
        chk("t2_sub_result", result, 32'd0);
        chk("t2_sub_zero", {31'd0, zero}, 32'd1);
        send(4'h6, 32'hFFFF_FFFF, 32'd1);
        chk("t2_slt_valid", {31'd0, out_valid}, 32'd1);
        chk("t2_slt_result", result, 32'd1);
        idle();

        // 3: MULHIU latency and in_ready low while busy
        send(4'hD, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        in_valid = 1'b0;
        n        = 1;
        rdy_seen = 0;
        while (!out_valid && n < 100) begin
            if (in_ready) rdy_seen++;
            @(posedge clk);
            #1;
            n++;
        end
        chk("t3_latency", n, 32'd33);
        chk("t3_busy_in_ready", rdy_seen, 32'd0);
        chk("t3_result", result, 32'hFFFF_FFFE);
        idle();

        // 4: divide cases
        send(4'hE, 32'h64, 32'h0);
        in_valid = 1'b0;
        wait_valid(n);
        chk("t4_div0", result, 32'hFFFF_FFFF);
        chk("t4_div0_err", {31'd0, err}, 32'd0);
        idle();
        send(4'hF, 32'h64, 32'h7);
        in_valid = 1'b0;
        wait_valid(n);
        chk("t4_remu", result, 32'h2);
        idle();
        send(4'hE, 32'h64, 32'h7);
        in_valid = 1'b0;
        wait_valid(n);
        chk("t4_divu", result, 32'hE);
        idle();

        // 5: backpressure holds the result
        out_ready = 1'b0;
        send(4'h0, 32'd1, 32'd2);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t5_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("t5_hold_result", result, 32'd3);
            chk("t5_hold_in_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_released", {31'd0, out_valid}, 32'd0);

        // 6: reset in the middle of a divide, then ADD and illegal op
        send(4'hE, 32'h64, 32'h7);
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("t6_rst_zero", {31'd0, zero}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_post_in_ready", {31'd0, in_ready}, 32'd1);
        send(4'h0, 32'd2, 32'd2);
        in_valid = 1'b0;
        chk("t6_add", result, 32'd4);
        idle();
        send(4'hB, 32'h1234, 32'h5678);
        in_valid = 1'b0;
        chk("t6_err", {31'd0, err}, 32'd1);
        chk("t6_err_result", result, 32'd0);
        idle();
        send(4'h2, 32'hF0F0, 32'h0FF0);
        in_valid = 1'b0;
        chk("t6_err_cleared", {31'd0, err}, 32'd0);
        chk("t6_and", result, 32'h00F0);
        idle();

        // Sweep every opcode over a few operand pairs with random backpressure.
        va[0] = 32'h0000_0000; vb[0] = 32'h0000_0000;
        va[1] = 32'h8000_0000; vb[1] = 32'hFFFF_FFFF;
        va[2] = 32'hDEAD_BEEF; vb[2] = 32'h0000_0013;
        va[3] = 32'h1234_5678; vb[3] = 32'h9ABC_DEF0;
        rnd_rdy = 1'b1;
        for (int o = 0; o < 16; o++) begin
            for (int k = 0; k < 4; k++) begin
                send(4'(o), va[k], vb[k]);
            end
        end
        in_valid  = 1'b0;
        rnd_rdy   = 1'b0;
        out_ready = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("drain_queue_empty", q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
